// File: rtl/bp_be_pkg.sv
// Shared back-end types: processor configurations, the stride-prefetch FSM states and the page size.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_sv48_cfg
    } bp_params_e;

    typedef enum logic [1:0] {
        e_pf_idle,
        e_pf_train,
        e_pf_wait_iter,
        e_pf_issue
    } bp_be_stride_pf_state_e;

    localparam int unsigned bp_be_stride_pf_page_bits_gp = 12;

    function automatic int unsigned bp_vaddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_sv48_cfg: return 48;
            default:       return 39;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_stride_prefetch_if.sv
// Committed-load, iteration-count and prefetch-request signals of the stride prefetcher.
interface bp_be_stride_prefetch_if #(
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned iter_width_p  = 8
);
    logic                     ld_v_i;
    logic [vaddr_width_p-1:0] ld_pc_i;
    logic [vaddr_width_p-1:0] ld_vaddr_i;
    logic                     start_discovery_o;
    logic                     confirm_discovery_o;
    logic [vaddr_width_p-1:0] striding_pc_o;
    logic                     iter_v_i;
    logic [iter_width_p-1:0]  iter_i;
    logic                     iter_yumi_o;
    logic                     pf_v_o;
    logic [vaddr_width_p-1:0] pf_vaddr_o;
    logic                     pf_ready_and_i;

    modport master (
        output ld_v_i, ld_pc_i, ld_vaddr_i, iter_v_i, iter_i, pf_ready_and_i,
        input  start_discovery_o, confirm_discovery_o, striding_pc_o, iter_yumi_o, pf_v_o, pf_vaddr_o
    );

    modport slave (
        input  ld_v_i, ld_pc_i, ld_vaddr_i, iter_v_i, iter_i, pf_ready_and_i,
        output start_discovery_o, confirm_discovery_o, striding_pc_o, iter_yumi_o, pf_v_o, pf_vaddr_o
    );
endinterface

// File: rtl/bp_be_stride_pf_agen.sv
// Prefetch address generator: accumulates the stride and flags page crossings of the next address.
// BP_BE_STRIDE_PF_PAGE_CLAMP_EN enables the crossing flags; otherwise they are tied low.
module bp_be_stride_pf_agen
    import bp_be_pkg::*;
#(
    parameter int unsigned vaddr_width_p = 39
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic                     step,
    input  logic [vaddr_width_p-1:0] last,
    input  logic [vaddr_width_p-1:0] stride,
    output logic [vaddr_width_p-1:0] addr,
    output logic                     cross_first_c,
    output logic                     cross_next_c
);
    logic [vaddr_width_p-1:0] addr_r;
    logic [vaddr_width_p-1:0] first;
    logic [vaddr_width_p-1:0] next;

    assign first = last + stride;
    assign next  = addr_r + stride;

    always_ff @(posedge clk) begin
        if (!reset_n)  addr_r <= '0;
        else if (load) addr_r <= first;
        else if (step) addr_r <= next;
    end

    assign addr = addr_r;

    // Crossings are judged against the page of the last trained load address.
`ifdef BP_BE_STRIDE_PF_PAGE_CLAMP_EN
    assign cross_first_c = first[vaddr_width_p-1:bp_be_stride_pf_page_bits_gp]
                        != last[vaddr_width_p-1:bp_be_stride_pf_page_bits_gp];
    assign cross_next_c  = next[vaddr_width_p-1:bp_be_stride_pf_page_bits_gp]
                        != last[vaddr_width_p-1:bp_be_stride_pf_page_bits_gp];
`else
    assign cross_first_c = 1'b0;
    assign cross_next_c  = 1'b0;
`endif

endmodule

// File: rtl/bp_be_stride_prefetch.sv
// Stride prefetcher: trains on one load PC, confirms a constant stride, then issues bounded prefetches.
// Optional page clamp via BP_BE_STRIDE_PF_PAGE_CLAMP_EN (implemented in bp_be_stride_pf_agen).
module bp_be_stride_prefetch
    import bp_be_pkg::*;
#(
    parameter bp_params_e  bp_params_p         = e_bp_default_cfg,
    parameter int unsigned confirm_threshold_p = 3,
    parameter int unsigned max_prefetch_p      = 16,
    parameter int unsigned iter_width_p        = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_be_stride_prefetch_if.slave   bus
);
    localparam int unsigned vaddr_width_p = bp_vaddr_width(bp_params_p);
    localparam int unsigned conf_width_lp = $clog2(confirm_threshold_p + 1);
    localparam int unsigned cnt_width_lp  = $clog2(max_prefetch_p + 1);

    bp_be_stride_pf_state_e   state_r, state_n;
    logic [vaddr_width_p-1:0] pc_r, pc_n, last_r, last_n, stride_r, stride_n;
    logic [conf_width_lp-1:0] conf_r, conf_n;
    logic [cnt_width_lp-1:0]  cnt_r, cnt_n;
    logic                     start_r, start_n, confirm_r, confirm_n;

    logic [vaddr_width_p-1:0] d, pf_addr;
    logic [cnt_width_lp-1:0]  iter_min;
    logic                     ld_match, pf_load, pf_step, iter_yumi_c;
    logic                     cross_first_c, cross_next_c;

    bp_be_stride_pf_agen #(.vaddr_width_p(vaddr_width_p)) agen (
        .clk           (clk_i),
        .reset_n       (reset_n_i),
        .load          (pf_load),
        .step          (pf_step),
        .last          (last_r),
        .stride        (stride_r),
        .addr          (pf_addr),
        .cross_first_c (cross_first_c),
        .cross_next_c  (cross_next_c)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r   <= e_pf_idle;
            pc_r      <= '0;
            last_r    <= '0;
            stride_r  <= '0;
            conf_r    <= '0;
            cnt_r     <= '0;
            start_r   <= 1'b0;
            confirm_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            pc_r      <= pc_n;
            last_r    <= last_n;
            stride_r  <= stride_n;
            conf_r    <= conf_n;
            cnt_r     <= cnt_n;
            start_r   <= start_n;
            confirm_r <= confirm_n;
        end
    end

    always_comb begin
        state_n     = state_r;
        pc_n        = pc_r;
        last_n      = last_r;
        stride_n    = stride_r;
        conf_n      = conf_r;
        cnt_n       = cnt_r;
        start_n     = 1'b0;
        confirm_n   = 1'b0;
        pf_load     = 1'b0;
        pf_step     = 1'b0;
        iter_yumi_c = 1'b0;

        d        = bus.ld_vaddr_i - last_r;
        ld_match = bus.ld_v_i && (bus.ld_pc_i == pc_r);
        iter_min = (32'(bus.iter_i) > max_prefetch_p) ? cnt_width_lp'(max_prefetch_p)
                                                      : cnt_width_lp'(bus.iter_i);

        case (state_r)
            e_pf_idle: begin
                if (bus.ld_v_i) begin
                    pc_n     = bus.ld_pc_i;
                    last_n   = bus.ld_vaddr_i;
                    stride_n = '0;
                    conf_n   = '0;
                    state_n  = e_pf_train;
                end
            end
            e_pf_train: begin
                if (ld_match) begin
                    last_n = bus.ld_vaddr_i;
                    if ((d == stride_r) && (d != '0)) begin
                        if (32'(conf_r) < confirm_threshold_p) conf_n = conf_r + 1'b1;
                        start_n = (conf_r == '0);
                        if (conf_n == conf_width_lp'(confirm_threshold_p)) begin
                            confirm_n = 1'b1;
                            state_n   = e_pf_wait_iter;
                        end
                    end else begin
                        stride_n = d;
                        conf_n   = '0;
                    end
                end
            end
            e_pf_wait_iter: begin
                iter_yumi_c = bus.iter_v_i;
                if (bus.iter_v_i) begin
                    cnt_n   = iter_min;
                    pf_load = 1'b1;
                    state_n = ((iter_min == '0) || cross_first_c) ? e_pf_idle : e_pf_issue;
                end
            end
            e_pf_issue: begin
                if (bus.pf_ready_and_i) begin
                    cnt_n   = cnt_r - 1'b1;
                    pf_step = 1'b1;
                    if ((cnt_r == cnt_width_lp'(1)) || cross_next_c) state_n = e_pf_idle;
                end
            end
            default: state_n = e_pf_idle;
        endcase
    end

    // Outputs are forced low while reset is held, including the first reset cycle.
    assign bus.start_discovery_o   = reset_n_i & start_r;
    assign bus.confirm_discovery_o = reset_n_i & confirm_r;
    assign bus.striding_pc_o       = reset_n_i ? pc_r : '0;
    assign bus.iter_yumi_o         = reset_n_i & iter_yumi_c;
    assign bus.pf_v_o              = reset_n_i & (state_r == e_pf_issue);
    assign bus.pf_vaddr_o          = reset_n_i ? pf_addr : '0;

endmodule

// File: doc/bp_be_stride_prefetch.md
BP_BE_STRIDE_PREFETCH -- requirements
Module: bp_be_stride_prefetch

Interface
REQ-001 SHALL take parameter bp_params_p, default e_bp_default_cfg, processor configuration that supplies vaddr_width_p.
REQ-002 SHALL take parameter confirm_threshold_p, default 3, the number of consecutive equal nonzero strides that confirms discovery.
REQ-003 SHALL take parameter max_prefetch_p, default 16, the cap on prefetches issued per discovery.
REQ-004 SHALL take parameter iter_width_p, default 8, the width of the iteration-count input.
REQ-005 clk_i  input  1  clock; all state changes on its rising edge.
REQ-006 reset_n_i  input  1  synchronous, active-low reset.
REQ-007 ld_v_i  input  1  committed load valid, one cycle per load.
REQ-008 ld_pc_i  input  vaddr_width_p  PC of the committed load.
REQ-009 ld_vaddr_i  input  vaddr_width_p  effective address of the committed load.
REQ-010 start_discovery_o  output  1  single-cycle pulse; the loop-inference unit begins scouting.
REQ-011 confirm_discovery_o  output  1  single-cycle pulse; locks in the current discovery.
REQ-012 striding_pc_o  output  vaddr_width_p  PC of the candidate load; held stable outside IDLE.
REQ-013 iter_v_i  input  1  remaining-iteration count valid.
REQ-014 iter_i  input  iter_width_p  remaining iterations, unsigned.
REQ-015 iter_yumi_o  output  1  consumes iter_i; asserted only in the same cycle as iter_v_i.
REQ-016 pf_v_o  output  1  prefetch request valid.
REQ-017 pf_vaddr_o  output  vaddr_width_p  prefetch address.
REQ-018 pf_ready_and_i  input  1  prefetch sink ready; a transfer occurs when pf_v_o & pf_ready_and_i.

Function
REQ-019 SHALL implement FSM states IDLE, TRAIN, WAIT_ITER and ISSUE.
REQ-020 IDLE: on ld_v_i, latch pc_r=ld_pc_i, last_r=ld_vaddr_i, stride_r=0, conf_r=0, then go to TRAIN.
REQ-021 TRAIN: ignore loads with ld_pc_i != pc_r; for a matching load, form d=ld_vaddr_i-last_r (modulo 2^vaddr_width_p, interpreted signed) and set last_r=ld_vaddr_i.
REQ-022 TRAIN, d==stride_r and d!=0: increment conf_r, saturating at confirm_threshold_p.
REQ-023 TRAIN, otherwise: set stride_r=d and conf_r=0.
REQ-024 SHALL assert start_discovery_o the cycle after conf_r transitions 0->1, and again after every later 0->1 transition while in TRAIN.
REQ-025 When conf_r reaches confirm_threshold_p, SHALL pulse confirm_discovery_o in the following cycle and go to WAIT_ITER.
REQ-026 WAIT_ITER: iter_yumi_o = iter_v_i; on that handshake, cnt_r = min(iter_i, max_prefetch_p) and pf_addr_r = last_r+stride_r.
REQ-027 WAIT_ITER: if the latched count is 0, go to IDLE; otherwise go to ISSUE.
REQ-028 ISSUE: pf_v_o=1 and pf_vaddr_o=pf_addr_r; on each transfer, cnt_r-- and pf_addr_r+=stride_r.
REQ-029 Address arithmetic SHALL wrap modulo 2^vaddr_width_p; negative strides are legal.
REQ-030 ISSUE SHALL go to IDLE on the transfer that brings cnt_r to 0.
REQ-031 pf_v_o SHALL NOT drop, nor pf_vaddr_o change, until the pending request transfers.
REQ-032 ld_v_i in WAIT_ITER or ISSUE SHALL be ignored.
REQ-033 iter_v_i outside WAIT_ITER SHALL be ignored, with iter_yumi_o=0.
REQ-034 A load arriving in the same cycle as the ISSUE->IDLE transition SHALL NOT be captured.
REQ-035 Latency: ld_v_i to start_discovery_o is 1 cycle; iter handshake to first pf_v_o is 1 cycle.

Reset
REQ-036 reset_n_i=0 SHALL force IDLE and clear pc_r, last_r, stride_r, conf_r, cnt_r and pf_addr_r.
REQ-037 During reset, all outputs SHALL be 0.
REQ-038 Reset in any state, including mid-ISSUE, SHALL abandon the operation with no further pf_v_o.
REQ-039 The first capture after reset SHALL occur in the cycle after reset_n_i rises.

Configuration
REQ-040 BP_BE_STRIDE_PF_PAGE_CLAMP_EN defined: ISSUE SHALL end (go to IDLE, pf_v_o=0) before issuing any address whose bits [vaddr_width_p-1:12] differ from those of last_r.
REQ-041 BP_BE_STRIDE_PF_PAGE_CLAMP_EN undefined: no page check; exactly the latched count of prefetches SHALL be issued.

Structure
REQ-042 State enum bp_be_stride_pf_state_e and constant bp_be_stride_pf_page_bits_gp=12 SHALL reside in bp_be_pkg.
REQ-043 Address accumulation and the page-clamp check SHALL be a single sub-module, bp_be_stride_pf_agen; the FSM, counters and handshakes remain in the top module.

Verification
REQ-044 Loads pc=0x100 at addresses 0x1000, 0x1040, 0x1080, 0x10C0, 0x1100 -> start_discovery_o after the 3rd load, confirm_discovery_o after the 5th, striding_pc_o=0x100.
REQ-045 After confirm, iter_v_i=1 with iter_i=4, pf_ready_and_i=1 -> iter_yumi_o=1 that cycle; pf_vaddr_o = 0x1140, 0x1180, 0x11C0, 0x1200 on consecutive cycles; then IDLE.
REQ-046 iter_i=128 -> exactly 16 prefetches; pf_ready_and_i toggled every other cycle -> address held stable while stalled.
REQ-047 Training 0x1000, 0x1040, 0x1050 (stride change) -> conf_r resets and a second start_discovery_o follows the next 0x10 stride.
REQ-048 Stride -8 from 0x0010 with iter_i=3 -> addresses wrap to 0xFF..F8 width-correctly; with CLAMP_EN, zero prefetches from the crossing point.
REQ-049 reset_n_i=0 on the 2nd prefetch cycle -> pf_v_o=0 the next cycle; a fresh load then restarts TRAIN.
